// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage_if
//  Description : Bundles the fetch-stage control inputs, the instruction
//                memory port and the IF/ID register outputs.
//                master : the fetch stage itself (drives imem_addr, IF/ID)
//                slave  : the environment (drives stall/redirects/imem_data)
//  Signals     : stall, branch_taken, branch_target[31:0], jump,
//                jump_index[25:0], imem_addr[31:0], imem_data[31:0],
//                instr_out[31:0], pc_plus4_out[31:0], valid_out, halted,
//                fetch_count[31:0]
//  Revision    : 1.0 - initial release
// ============================================================================
interface if_stage_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr_out;
    logic [31:0] pc_plus4_out;
    logic        valid_out;
    logic        halted;
    logic [31:0] fetch_count;

    modport master (
        input  stall, branch_taken, branch_target, jump, jump_index, imem_data,
        output imem_addr, instr_out, pc_plus4_out, valid_out, halted, fetch_count
    );

    modport slave (
        output stall, branch_taken, branch_target, jump, jump_index, imem_data,
        input  imem_addr, instr_out, pc_plus4_out, valid_out, halted, fetch_count
    );
endinterface
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : Instruction fetch stage. Holds the PC, presents it to the
//                instruction memory, and captures the returned word plus
//                PC+4 into the IF/ID register. Supports stall, branch and
//                jump redirects, and stops fetching on HALT_OPCODE.
//  Ports       : clk   - clock, all state updates on rising edge
//                reset - synchronous active-high reset
//                bus   - if_stage_if.master (control, imem port, IF/ID)
//  Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  wire logic   clk,
    input  wire logic   reset,
    if_stage_if.master  bus
);

    localparam logic [1:0] c_st_boot = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_halt = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_jump_target;
    logic        w_load_fetch;
    logic        w_load_bubble;
    logic [31:0] r_instr;
    logic [31:0] r_pc_plus4;
    logic        r_valid;
    logic [31:0] r_fetch_count;

    // Natural 32-bit wrap: 0xFFFFFFFC + 4 = 0
    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_jump_target = {w_pc_plus4[31:28], bus.jump_index, 2'b00};

    // Next-state / next-PC. When neither load flag is set the IF/ID register
    // holds (stall without redirect).
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_load_fetch  = 1'b0;
        w_load_bubble = 1'b0;
        case (r_state)
            c_st_boot: begin
                // One settling cycle: PC stays at RESET_PC, nothing fetched
                w_pc_nxt      = RESET_PC;
                w_load_bubble = 1'b1;
                w_state_nxt   = c_st_run;
            end
            c_st_run: begin
                if (bus.branch_taken) begin
                    w_pc_nxt      = bus.branch_target;
                    w_load_bubble = 1'b1;
                end else if (bus.jump) begin
                    w_pc_nxt      = w_jump_target;
                    w_load_bubble = 1'b1;
                end else if (!bus.stall) begin
                    w_pc_nxt     = w_pc_plus4;
                    w_load_fetch = 1'b1;
                    // The halt word itself is still delivered downstream
                    if (bus.imem_data[31:26] == HALT_OPCODE) begin
                        w_state_nxt = c_st_halt;
                    end
                end
            end
            c_st_halt: begin
                // Redirects ignored; only reset leaves this state
                w_load_bubble = 1'b1;
            end
            default: begin
                w_state_nxt   = c_st_boot;
                w_pc_nxt      = RESET_PC;
                w_load_bubble = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_st_boot;
            r_pc          <= RESET_PC;
            r_instr       <= 32'd0;
            r_pc_plus4    <= 32'd0;
            r_valid       <= 1'b0;
            r_fetch_count <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_load_fetch) begin
                r_instr       <= bus.imem_data;
                r_pc_plus4    <= w_pc_plus4;
                r_valid       <= 1'b1;
                r_fetch_count <= r_fetch_count + 32'd1;
            end else if (w_load_bubble) begin
                r_instr    <= 32'd0;
                r_pc_plus4 <= 32'd0;
                r_valid    <= 1'b0;
            end
        end
    end

    // PC is passed through unmodified, including bits [1:0]
    assign bus.imem_addr    = r_pc;
    assign bus.instr_out    = r_instr;
    assign bus.pc_plus4_out = r_pc_plus4;
    assign bus.valid_out    = r_valid;
    assign bus.halted       = (r_state == c_st_halt);
    assign bus.fetch_count  = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_stage
//  Description : Self-checking testbench for if_stage. A reference model
//                computes the expected IF/ID contents for every driven cycle
//                and pushes them to a scoreboard queue; they are popped and
//                compared after the clock edge. Directed constant checks
//                cover the documented scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] p4;
        logic        valid;
        logic        halted;
        logic [31:0] count;
    } exp_t;

    localparam int c_boot = 0;
    localparam int c_run  = 1;
    localparam int c_halt = 2;

    logic clk = 1'b0;
    logic reset;
    if_stage_if bus ();

    if_stage #(
        .RESET_PC    (32'h0000_0000),
        .HALT_OPCODE (6'b111111)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    exp_t        sb[$];
    logic [31:0] halt_addr = 32'hFFFF_FFF0;

    int          m_state;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_p4;
    logic        m_valid;
    logic [31:0] m_count;

    // Instruction memory: word at byte address a is 0x2008_nnnn with
    // nnnn = a/4 + 1, except the halt word at halt_addr.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] k;
        if (a == halt_addr) return 32'hFC00_0000;
        k = (a >> 2) + 32'd1;
        return {16'h2008, k[15:0]};
    endfunction

    always_comb bus.imem_data = mem_word(bus.imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL %s scoreboard_empty observed=0 expected=1", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, ".pc"},     bus.imem_addr,           e.pc);
            check({tag, ".instr"},  bus.instr_out,           e.instr);
            check({tag, ".p4"},     bus.pc_plus4_out,        e.p4);
            check({tag, ".valid"},  {31'd0, bus.valid_out},  {31'd0, e.valid});
            check({tag, ".halted"}, {31'd0, bus.halted},     {31'd0, e.halted});
            check({tag, ".count"},  bus.fetch_count,         e.count);
        end
    endtask

    task automatic do_reset(input string tag, input logic st, input logic br, input logic jp);
        exp_t e;
        reset             = 1'b1;
        bus.stall         = st;
        bus.branch_taken  = br;
        bus.branch_target = 32'h0000_0500;
        bus.jump          = jp;
        bus.jump_index    = 26'h0000_0AA;
        m_state = c_boot;
        m_pc    = 32'h0000_0000;
        m_instr = 32'd0;
        m_p4    = 32'd0;
        m_valid = 1'b0;
        m_count = 32'd0;
        e = '{pc: m_pc, instr: m_instr, p4: m_p4, valid: m_valid, halted: 1'b0, count: m_count};
        sb.push_back(e);
        @(posedge clk);
        #1;
        reset = 1'b0;
        pop_compare(tag);
    endtask

    task automatic step(input string tag, input logic st, input logic br, input logic jp,
                        input logic [31:0] tgt, input logic [25:0] idx);
        exp_t        e;
        logic [31:0] word;
        logic [31:0] p4;
        bus.stall         = st;
        bus.branch_taken  = br;
        bus.branch_target = tgt;
        bus.jump          = jp;
        bus.jump_index    = idx;
        p4 = m_pc + 32'd4;
        if (m_state == c_boot) begin
            m_pc = 32'h0000_0000;
            m_instr = 32'd0; m_p4 = 32'd0; m_valid = 1'b0;
            m_state = c_run;
        end else if (m_state == c_halt) begin
            m_instr = 32'd0; m_p4 = 32'd0; m_valid = 1'b0;
        end else if (br) begin
            m_pc = tgt;
            m_instr = 32'd0; m_p4 = 32'd0; m_valid = 1'b0;
        end else if (jp) begin
            m_pc = {p4[31:28], idx, 2'b00};
            m_instr = 32'd0; m_p4 = 32'd0; m_valid = 1'b0;
        end else if (!st) begin
            word    = mem_word(m_pc);
            m_instr = word;
            m_p4    = p4;
            m_valid = 1'b1;
            m_count = m_count + 32'd1;
            m_pc    = p4;
            if (word[31:26] == 6'b111111) m_state = c_halt;
        end
        e = '{pc: m_pc, instr: m_instr, p4: m_p4, valid: m_valid,
              halted: (m_state == c_halt), count: m_count};
        sb.push_back(e);
        @(posedge clk);
        #1;
        pop_compare(tag);
    endtask

    initial begin
        reset             = 1'b0;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'd0;
        bus.jump          = 1'b0;
        bus.jump_index    = 26'd0;
        #2;

        // Reset and first fetches
        do_reset("reset0", 1'b0, 1'b0, 1'b0);
        step("boot", 0, 0, 0, 32'd0, 26'd0);
        check("boot_valid", {31'd0, bus.valid_out}, 32'd0);
        check("boot_pc", bus.imem_addr, 32'h0000_0000);
        step("fetch1", 0, 0, 0, 32'd0, 26'd0);
        check("fetch1_instr", bus.instr_out, 32'h2008_0001);
        check("fetch1_p4", bus.pc_plus4_out, 32'd4);
        step("fetch2", 0, 0, 0, 32'd0, 26'd0);
        step("fetch3", 0, 0, 0, 32'd0, 26'd0);
        check("fetch3_p4", bus.pc_plus4_out, 32'd12);
        check("fetch3_count", bus.fetch_count, 32'd3);
        step("fetch4", 0, 0, 0, 32'd0, 26'd0);
        check("pc_0x10", bus.imem_addr, 32'h0000_0010);

        // Stall holds everything
        for (int i = 0; i < 3; i++) step("stall", 1, 0, 0, 32'd0, 26'd0);
        check("stall_pc", bus.imem_addr, 32'h0000_0010);
        check("stall_count", bus.fetch_count, 32'd4);
        step("release", 0, 0, 0, 32'd0, 26'd0);
        check("release_pc", bus.imem_addr, 32'h0000_0014);

        // Jump without and with stall
        step("br_a", 0, 1, 0, 32'h4000_0010, 26'd0);
        step("jump", 0, 0, 1, 32'd0, 26'h000_0100);
        check("jump_pc", bus.imem_addr, 32'h4000_0400);
        check("jump_valid", {31'd0, bus.valid_out}, 32'd0);
        step("br_b", 0, 1, 0, 32'h4000_0010, 26'd0);
        step("jump_stall", 1, 0, 1, 32'd0, 26'h000_0100);
        check("jump_stall_pc", bus.imem_addr, 32'h4000_0400);
        check("jump_stall_valid", {31'd0, bus.valid_out}, 32'd0);

        // Branch beats jump
        step("br_jump", 0, 1, 1, 32'h0000_0080, 26'h000_0003);
        check("br_jump_pc", bus.imem_addr, 32'h0000_0080);

        // Redirect on the halt-word cycle wins
        halt_addr = 32'h0000_0200;
        step("to_halt1", 0, 1, 0, 32'h0000_0200, 26'd0);
        step("redir_halt", 0, 1, 0, 32'h0000_0300, 26'd0);
        check("redir_halt_halted", {31'd0, bus.halted}, 32'd0);
        check("redir_halt_pc", bus.imem_addr, 32'h0000_0300);

        // Halt
        step("to_halt2", 0, 1, 0, 32'h0000_0200, 26'd0);
        step("halt_fetch", 0, 0, 0, 32'd0, 26'd0);
        check("halt_word", bus.instr_out, 32'hFC00_0000);
        check("halt_word_valid", {31'd0, bus.valid_out}, 32'd1);
        step("halt_jump", 0, 0, 1, 32'd0, 26'h000_0001);
        check("halt_halted", {31'd0, bus.halted}, 32'd1);
        check("halt_valid", {31'd0, bus.valid_out}, 32'd0);
        check("halt_pc", bus.imem_addr, 32'h0000_0204);
        step("halt_branch", 0, 1, 0, 32'h0000_0080, 26'd0);
        check("halt_pc2", bus.imem_addr, 32'h0000_0204);

        // Reset out of halt while other inputs are active
        do_reset("reset_halt", 1'b1, 1'b1, 1'b1);
        check("reset_halt_halted", {31'd0, bus.halted}, 32'd0);
        check("reset_halt_pc", bus.imem_addr, 32'h0000_0000);

        // PC wrap
        step("boot2", 0, 0, 0, 32'd0, 26'd0);
        step("br_top", 0, 1, 0, 32'hFFFF_FFFC, 26'd0);
        step("wrap", 0, 0, 0, 32'd0, 26'd0);
        check("wrap_p4", bus.pc_plus4_out, 32'h0000_0000);
        check("wrap_pc", bus.imem_addr, 32'h0000_0000);

        // Reset mid-stall
        step("pre_stall", 1, 0, 0, 32'd0, 26'd0);
        do_reset("reset_stall", 1'b1, 1'b0, 1'b0);
        step("boot3", 0, 0, 0, 32'd0, 26'd0);
        step("fetch_after", 0, 0, 0, 32'd0, 26'd0);
        check("fetch_after_count", bus.fetch_count, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
